// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants, K table, sigma functions and FSM encoding for the message scheduler
//
// Contents:
//   ROUNDS, MSG_WORDS - schedule length and message block length in words
//   sched_state_e     - scheduler states (ST_LOAD, ST_RUN)
//   K_TABLE           - 64 SHA-256 round constants, indexed by round
//   s0 / s1           - small sigma functions used to extend the schedule
package sha256_pkg;

  localparam int ROUNDS    = 64;
  localparam int MSG_WORDS = 16;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  localparam logic [31:0] K_TABLE [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // s0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // s1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// rtl/sha256_msg_sched_if.sv - message-word input and W/K output handshakes of the scheduler
//
// Signals:
//   in_valid/in_ready/in_word     - message word stream into the scheduler
//   w_valid/w_ready/W/K/round/w_last - schedule word stream to the round stage
// Modports: slave = scheduler side, master = producer/consumer side.
interface sha256_msg_sched_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] W;
  logic [31:0] K;
  logic [5:0]  round;
  logic        w_last;

  modport slave (
    input  in_valid, in_word, w_ready,
    output in_ready, w_valid, W, K, round, w_last
  );

  modport master (
    output in_valid, in_word, w_ready,
    input  in_ready, w_valid, W, K, round, w_last
  );

endinterface

// File: rtl/sha256_k_rom.sv
// rtl/sha256_k_rom.sv - combinational SHA-256 round-constant lookup
//
// Ports:
//   i_addr - round index 0..63
//   o_k    - round constant K[i_addr]
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  i_addr,
  output logic [31:0] o_k
);

  assign o_k = K_TABLE[i_addr];

endmodule

// File: rtl/sha256_msg_sched.sv
// rtl/sha256_msg_sched.sv - SHA-256 message schedule generator (16-word load, 64 W/K outputs)
//
// Ports:
//   ACLK    - clock, rising edge
//   ARESETN - synchronous active-low reset
//   abort   - (only with SHA256_SCHED_ABORT_EN) drop the current block and return to LOAD
//   bus     - sha256_msg_sched_if.slave: word input stream and W/K/round output stream
// Build option: define SHA256_SCHED_ABORT_EN to add the abort input.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic ACLK,
  input  logic ARESETN,
`ifdef SHA256_SCHED_ABORT_EN
  input  logic abort,
`endif
  sha256_msg_sched_if.slave bus
);

  sched_state_e r_state;
  sched_state_e w_state_nxt;
  logic [31:0]  r_window [MSG_WORDS];
  logic [3:0]   r_load_cnt;
  logic [5:0]   r_round;

  logic         w_abort;
  logic         w_in_fire;
  logic         w_out_fire;
  logic [31:0]  w_new_word;
  logic [31:0]  w_k;

`ifdef SHA256_SCHED_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Handshakes only complete in the state that owns them, so in_valid in RUN
  // and w_ready in LOAD are simply ignored.
  assign w_in_fire  = bus.in_valid & (r_state == ST_LOAD);
  assign w_out_fire = bus.w_ready  & (r_state == ST_RUN);

  // W[t+16] from the window holding W[t..t+15].
  assign w_new_word = s1(r_window[14]) + r_window[9] + s0(r_window[1]) + r_window[0];

  sha256_k_rom u_k_rom (
    .i_addr (r_round),
    .o_k    (w_k)
  );

  always_comb begin
    w_state_nxt  = r_state;
    bus.in_ready = 1'b0;
    bus.w_valid  = 1'b0;
    bus.w_last   = 1'b0;
    bus.W        = r_window[0];
    bus.K        = w_k;
    bus.round    = r_round;
    case (r_state)
      ST_LOAD: begin
        bus.in_ready = 1'b1;
        if (w_in_fire && (r_load_cnt == 4'(MSG_WORDS - 1))) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        bus.w_valid = 1'b1;
        bus.w_last  = (r_round == 6'(ROUNDS - 1));
        if (w_out_fire && (r_round == 6'(ROUNDS - 1))) begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // Load count and round are natural-width counters: the 16th word wraps the
  // load count to 0 and the round-63 transfer wraps round to 0, which are
  // exactly the values the next block starts from.
  always_ff @(posedge ACLK) begin
    if (!ARESETN || w_abort) begin
      r_state    <= ST_LOAD;
      r_load_cnt <= '0;
      r_round    <= '0;
      for (int i = 0; i < MSG_WORDS; i++) begin
        r_window[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_in_fire || w_out_fire) begin
        for (int i = 0; i < MSG_WORDS - 1; i++) begin
          r_window[i] <= r_window[i + 1];
        end
        r_window[MSG_WORDS - 1] <= w_in_fire ? bus.in_word : w_new_word;
      end
      if (w_in_fire) begin
        r_load_cnt <= r_load_cnt + 4'd1;
      end
      if (w_out_fire) begin
        r_round <= r_round + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb/tb_sha256_msg_sched.sv - self-checking bench for sha256_msg_sched against a schedule reference model
module tb_sha256_msg_sched;

  logic clk;
  logic rstn;
`ifdef SHA256_SCHED_ABORT_EN
  logic abort;
`endif

  sha256_msg_sched_if bus ();

  sha256_msg_sched dut (
    .ACLK    (clk),
    .ARESETN (rstn),
`ifdef SHA256_SCHED_ABORT_EN
    .abort   (abort),
`endif
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int acc_words;

  logic [31:0] kexp [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] blk  [16];
  logic [31:0] wexp [64];

  always @(posedge clk) begin
    if (rstn && bus.in_valid && bus.in_ready) acc_words++;
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build_expected();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) wexp[t] = blk[t];
      else wexp[t] = (rotr(wexp[t-2], 17) ^ rotr(wexp[t-2], 19) ^ (wexp[t-2] >> 10))
                   + wexp[t-7]
                   + (rotr(wexp[t-15], 7) ^ rotr(wexp[t-15], 18) ^ (wexp[t-15] >> 3))
                   + wexp[t-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    build_expected();
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    build_expected();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_w_valid"},  bus.w_valid,  0);
    chk({tag, "_w_last"},   bus.w_last,   0);
    chk({tag, "_W"},        bus.W,        0);
    chk({tag, "_K"},        bus.K,        32'h428a2f98);
    chk({tag, "_round"},    bus.round,    0);
  endtask

  // Offers nwords of blk; with hold_valid, in_valid stays high afterwards.
  task automatic load_block(input int nwords, input int gap_pct, input bit hold_valid);
    int n = 0;
    int guard = 0;
    while (n < nwords && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (!hold_valid && $urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
      end else begin
        chk("load_in_ready", bus.in_ready, 1);
        chk("load_w_valid", bus.w_valid, 0);
        bus.in_valid = 1'b1;
        bus.in_word  = blk[n];
        n++;
      end
    end
    chk("load_words_offered", n, nwords);
    if (nwords == 16) begin
      @(negedge clk);
      if (!hold_valid) bus.in_valid = 1'b0;
      chk("first_round_w_valid", bus.w_valid, 1);
      chk("first_round_round", bus.round, 0);
      chk("first_round_W", bus.W, blk[0]);
    end
  endtask

  // Checks rounds 0..stop_at-1; a stalled cycle re-checks the same round next cycle.
  // The first check happens at the current negedge (caller leaves us right after load).
  task automatic run_block(input int stall_pct, input int stop_at);
    int t = 0;
    int guard = 0;
    bit first = 1'b1;
    while (t < stop_at && guard < 5000) begin
      if (!first) @(negedge clk);
      first = 1'b0;
      guard++;
      chk("run_w_valid",  bus.w_valid,  1);
      chk("run_in_ready", bus.in_ready, 0);
      chk("run_W",        bus.W,        wexp[t]);
      chk("run_K",        bus.K,        kexp[t]);
      chk("run_round",    bus.round,    t[5:0]);
      chk("run_w_last",   bus.w_last,   (t == 63) ? 1 : 0);
      if ($urandom_range(99) < stall_pct) begin
        bus.w_ready = 1'b0;
      end else begin
        bus.w_ready = 1'b1;
        t++;
      end
    end
    chk("run_transfers", t, stop_at);
  endtask

  task automatic end_of_block();
    @(negedge clk);
    bus.w_ready = 1'b0;
    chk("done_in_ready", bus.in_ready, 1);
    chk("done_w_valid",  bus.w_valid,  0);
  endtask

  initial begin
    int acc0;
    checks = 0;
    failures = 0;
    acc_words = 0;
    rstn = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_word  = 32'h0;
    bus.w_ready  = 1'b0;
`ifdef SHA256_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rstn = 1'b1;

    // "abc" block, no stalls, no gaps
    set_abc();
    acc0 = acc_words;
    load_block(16, 0, 1'b0);
    run_block(0, 64);
    chk("abc_words_accepted", acc_words - acc0, 16);
    end_of_block();

    // "abc" block with random input gaps and output stalls
    load_block(16, 30, 1'b0);
    run_block(40, 64);
    end_of_block();

    // Two random blocks back to back with in_valid held high throughout
    for (int b = 0; b < 2; b++) begin
      set_random();
      acc0 = acc_words;
      load_block(16, 0, 1'b1);
      run_block((b == 0) ? 0 : 25, 64);
      chk("held_valid_words_per_block", acc_words - acc0, 16);
    end
    end_of_block();
    bus.in_valid = 1'b0;

    // Reset in the middle of RUN, then a clean "abc" block
    set_random();
    load_block(16, 0, 1'b0);
    run_block(0, 30);
    @(negedge clk);
    bus.w_ready = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check_idle("midrun_reset");
    @(negedge clk);
    check_idle("midrun_reset_hold");
    rstn = 1'b1;
    set_abc();
    load_block(16, 10, 1'b0);
    run_block(20, 64);
    end_of_block();

`ifdef SHA256_SCHED_ABORT_EN
    // Abort at load count 7 with a word offered in the same cycle
    set_random();
    load_block(7, 0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_word  = 32'hdeadbeef;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bus.in_valid = 1'b0;
    check_idle("abort_load");
    set_random();
    load_block(16, 0, 1'b0);
    run_block(0, 40);
    // Abort coincident with the round-40 transfer
    @(negedge clk);
    bus.w_ready = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bus.w_ready = 1'b0;
    check_idle("abort_run");
    set_abc();
    load_block(16, 0, 1'b0);
    run_block(10, 64);
    end_of_block();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
